nibble_fetch: RTL and testbench

NIBBLE_FETCH -- requirements
Module: nibble_fetch

---
 rtl/nibble_pkg.sv | 21 ++
 rtl/nibble_fetch.sv | 171 +++++++++++++++++
 tb/tb_nibble_fetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// nibble_pkg -- shared definitions for the nibble_fetch instruction fetch unit.
//
// Contents:
//   fetch_state_t  fetch FSM states (IDLE, REQ, HOLD)
//   OP_MSB/OP_LSB  opcode field position inside the instruction register
//   OPND_MSB       top bit of the operand nibble (operand is IR[OPND_MSB:0])
//   DEFAULT_PC_W   default program-counter / instruction-address width
package nibble_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int OP_MSB       = 7;
    localparam int OP_LSB       = 5;
    localparam int OPND_MSB     = 3;
    localparam int DEFAULT_PC_W = 8;

endpackage

// File: rtl/nibble_fetch.sv
// nibble_fetch -- instruction fetch unit for the nibble CPU.
//
// Fetches 8-bit instruction words from instruction memory at the current PC,
// holds each one in the instruction register (IR) until the control unit
// consumes it, and supports jumps that reload the PC and flush any fetched but
// unconsumed instruction.
//
// Optional feature: define NIBBLE_FETCH_PREFETCH_EN to compile in a one-entry
// prefetch buffer (PB) that fetches the next word while the current one is
// waiting to be consumed, allowing back-to-back issue.
//
// Handshakes:
//   imem  : imem_req is held with a stable imem_addr until imem_ack; imem_rdata
//           is sampled only on a cycle where imem_req=1 and imem_ack=1.
//   issue : op/operand are stable while ir_valid=1; an instruction is consumed
//           on a rising edge where ir_valid=1 and ir_ready=1. ir_ready with
//           ir_valid=0 has no effect. jump overrides both handshakes.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   imem_req   out  instruction-memory read request
//   imem_addr  out  read address (= pc)
//   imem_rdata in   instruction word, valid with imem_ack
//   imem_ack   in   memory returns imem_rdata for the outstanding request
//   op         out  opcode, IR[7:5]
//   operand    out  operand nibble, IR[3:0] (IR[4] reserved)
//   ir_valid   out  op/operand hold an unconsumed instruction
//   ir_ready   in   control unit consumes the instruction this cycle
//   jump       in   load pc from jump_addr and flush
//   jump_addr  in   jump target
//   pc         out  current program counter
//   state_dbg  out  current fetch FSM state (fetch_state_t encoding)
module nibble_fetch
    import nibble_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_rdata,
    input  logic            imem_ack,
    output logic [2:0]      op,
    output logic [3:0]      operand,
    output logic            ir_valid,
    input  logic            ir_ready,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      state_dbg
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [7:0]      ir_q, ir_d;

`ifdef NIBBLE_FETCH_PREFETCH_EN
    logic [7:0]      pb_q, pb_d;
    logic            pb_valid_q, pb_valid_d;
`endif

    // Wraps to zero past the top of the address space by natural truncation.
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        imem_req = 1'b0;
`ifdef NIBBLE_FETCH_PREFETCH_EN
        pb_d       = pb_q;
        pb_valid_d = pb_valid_q;
`endif

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_inc;
                    state_d = HOLD;
                end
            end

            HOLD: begin
`ifdef NIBBLE_FETCH_PREFETCH_EN
                // Keep fetching ahead while the buffer has room.
                imem_req = !pb_valid_q;
                if (ir_ready) begin
                    if (pb_valid_q) begin
                        // Back-to-back issue from the buffer.
                        ir_d       = pb_q;
                        pb_valid_d = 1'b0;
                    end else if (imem_ack) begin
                        // Returning word bypasses the empty buffer.
                        ir_d = imem_rdata;
                        pc_d = pc_inc;
                    end else begin
                        state_d = REQ;
                    end
                end else if (imem_ack && !pb_valid_q) begin
                    pb_d       = imem_rdata;
                    pb_valid_d = 1'b1;
                    pc_d       = pc_inc;
                end
`else
                if (ir_ready) begin
                    state_d = REQ;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Jump wins over everything above: any ack this cycle is dropped and
        // the IR keeps its old (now invalid) contents.
        if (jump) begin
            pc_d    = jump_addr;
            ir_d    = ir_q;
            state_d = REQ;
`ifdef NIBBLE_FETCH_PREFETCH_EN
            pb_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
`ifdef NIBBLE_FETCH_PREFETCH_EN
            pb_q       <= 8'h00;
            pb_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef NIBBLE_FETCH_PREFETCH_EN
            pb_q       <= pb_d;
            pb_valid_q <= pb_valid_d;
`endif
        end
    end

    // HOLD is exactly the set of cycles in which the IR holds a live
    // instruction, in both build variants.
    assign ir_valid  = (state_q == HOLD);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign op        = ir_q[OP_MSB:OP_LSB];
    assign operand   = ir_q[OPND_MSB:0];
    assign state_dbg = state_q;

    // IR[4] is a reserved bit that is stored but never decoded.
    logic unused_ir_bit;
    assign unused_ir_bit = ir_q[4];

endmodule

// File: tb/tb_nibble_fetch.sv
// tb_nibble_fetch -- self-checking bench for nibble_fetch.
//
// Directed phase covers reset values, first fetch latency, stalls, PC wrap,
// jump/ack collision and reset during a fetch. The random phase drives a
// memory model and checks the issued instruction stream against the rule
// "after a jump to A, the issued stream is mem[A], mem[A+1], ...".
module tb_nibble_fetch;
    import nibble_pkg::*;

    localparam int              PC_W     = 8;
    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_rdata;
    logic            imem_ack;
    logic [2:0]      op;
    logic [3:0]      operand;
    logic            ir_valid;
    logic            ir_ready;
    logic            jump;
    logic [PC_W-1:0] jump_addr;
    logic [PC_W-1:0] pc;
    logic [1:0]      state_dbg;

    always #5 clk = ~clk;

    nibble_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .op         (op),
        .operand    (operand),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [7:0]      mem [256];
    logic [6:0]      exp_q [$];
    logic [PC_W-1:0] exp_pc;
    int              n_tests = 0;
    int              n_fail  = 0;
    int              n_hs    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] decode(input logic [7:0] w);
        return {w[7:5], w[3:0]};
    endfunction

    task automatic sb_push();
        exp_q.push_back(decode(mem[exp_pc]));
        exp_pc = exp_pc + 1'b1;
    endtask

    task automatic sb_restart(input logic [PC_W-1:0] a);
        exp_q.delete();
        exp_pc = a;
        for (int i = 0; i < 16; i++) sb_push();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One randomized cycle: memory responder, control-unit ready, jumps,
    // and the stream check for any handshake about to happen on this edge.
    task automatic step(input int p_ack, input int p_ready, input int p_jump);
        logic [6:0] exp_word;
        jump       = ($urandom_range(99) < p_jump);
        jump_addr  = PC_W'($urandom);
        ir_ready   = ($urandom_range(99) < p_ready);
        imem_ack   = imem_req && ($urandom_range(99) < p_ack);
        imem_rdata = imem_ack ? mem[imem_addr] : 8'($urandom);
        if (jump) begin
            sb_restart(jump_addr);
        end else if (ir_valid && ir_ready) begin
            n_hs++;
            exp_word = exp_q.pop_front();
            sb_push();
            check("issue", {25'd0, op, operand}, {25'd0, exp_word});
        end
        tick();
    endtask

    task automatic idle_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        ir_ready   = 1'b0;
        jump       = 1'b0;
        jump_addr  = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] held_op;
        logic [3:0] held_opnd;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA5;

        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req",   imem_req,  0);
        check("rst_valid", ir_valid,  0);
        check("rst_op",    op,        0);
        check("rst_opnd",  operand,   0);
        check("rst_pc",    pc,        RESET_PC);
        check("rst_state", state_dbg, IDLE);

        // First fetch: IDLE->REQ, ack after 2 cycles with 8'hA5
        reset = 1'b1;
        tick();
        check("req_state", state_dbg, REQ);
        check("req_req",   imem_req,  1);
        check("req_addr",  imem_addr, 8'h00);
        tick();
        tick();
        check("req_stable_addr", imem_addr, 8'h00);
        check("req_stable_req",  imem_req,  1);
        imem_ack   = 1'b1;
        imem_rdata = mem[0];
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        check("fetch_valid", ir_valid, 1);
        check("fetch_op",    op,       3'b101);
        check("fetch_opnd",  operand,  4'h5);
        check("fetch_pc",    pc,       8'h01);

        // Stall in HOLD for 5 cycles
        held_op   = op;
        held_opnd = operand;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_op",    op,       held_op);
            check("stall_opnd",  operand,  held_opnd);
            check("stall_valid", ir_valid, 1);
`ifndef NIBBLE_FETCH_PREFETCH_EN
            check("stall_req",   imem_req, 0);
`endif
        end

        // Consume -> back to REQ at pc 1
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("consume_valid", ir_valid,  0);
        check("consume_req",   imem_req,  1);
        check("consume_addr",  imem_addr, 8'h01);

        // PC wrap: jump to 0xFF, fetch it
        jump      = 1'b1;
        jump_addr = 8'hFF;
        tick();
        jump = 1'b0;
        check("jmpff_addr",  imem_addr, 8'hFF);
        check("jmpff_valid", ir_valid,  0);
        imem_ack   = 1'b1;
        imem_rdata = mem[8'hFF];
        tick();
        imem_ack = 1'b0;
        check("wrap_pc",    pc,                8'h00);
        check("wrap_valid", ir_valid,          1);
        check("wrap_instr", {op, operand},     decode(mem[8'hFF]));

        // Jump colliding with ack: data dropped
        held_op   = op;
        held_opnd = operand;
        ir_ready  = 1'b1;
        tick();
        ir_ready   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = mem[0];
        jump       = 1'b1;
        jump_addr  = 8'h40;
        tick();
        idle_inputs();
        check("jmpack_valid", ir_valid,  0);
        check("jmpack_addr",  imem_addr, 8'h40);
        check("jmpack_pc",    pc,        8'h40);
        check("jmpack_op",    op,        held_op);
        check("jmpack_opnd",  operand,   held_opnd);

        // Reset pulse in the middle of REQ
        check("pre_rst_state", state_dbg, REQ);
        #2 reset = 1'b0;
        #1;
        check("async_req",   imem_req,  0);
        check("async_valid", ir_valid,  0);
        check("async_pc",    pc,        RESET_PC);
        check("async_op",    op,        0);
        check("async_opnd",  operand,   0);
        check("async_state", state_dbg, IDLE);
        imem_ack   = 1'b1;
        imem_rdata = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        check("rst_ack_ignored", ir_valid, 0);
        imem_ack = 1'b0;
        reset    = 1'b1;
        tick();
        check("restart_state", state_dbg, REQ);
        check("restart_addr",  imem_addr, RESET_PC);

        // Random phase against the stream model
        sb_restart(RESET_PC);
        n_hs = 0;
        for (int i = 0; i < 1500; i++) step(60, 60, 4);
        check("liveness", (n_hs >= 100), 1);

        // Memory always acks, control unit always ready
        idle_inputs();
        jump      = 1'b1;
        jump_addr = 8'h10;
        sb_restart(8'h10);
        tick();
        jump = 1'b0;
        n_hs = 0;
        for (int i = 0; i < 40; i++) begin
`ifdef NIBBLE_FETCH_PREFETCH_EN
            if (i >= 1) check("b2b_valid", ir_valid, 1);
`endif
            step(100, 100, 0);
        end
`ifdef NIBBLE_FETCH_PREFETCH_EN
        check("b2b_count", n_hs, 39);
`else
        check("b2b_count", n_hs, 20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
